// File: rtl/systolic_feed_ctrl_if.sv
// systolic_feed_ctrl_if: host write port, job control and array feed lanes of the feed controller
interface systolic_feed_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              wr_en;
   logic              wr_sel;
   logic [3:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              start;
   logic              busy;
   logic              done;
   logic              arr_rst;
   logic [DATA_W-1:0] feed_west0, feed_west1, feed_west2, feed_west3;
   logic [DATA_W-1:0] feed_north0, feed_north1, feed_north2, feed_north3;
   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start,
      input  busy, done, arr_rst,
      input  feed_west0, feed_west1, feed_west2, feed_west3,
      input  feed_north0, feed_north1, feed_north2, feed_north3
   );
   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start,
      output busy, done, arr_rst,
      output feed_west0, feed_west1, feed_west2, feed_west3,
      output feed_north0, feed_north1, feed_north2, feed_north3
   );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: operand storage and diagonally skewed feed sequencing for a 4x4 output-stationary array
module systolic_feed_ctrl #(
   parameter int DATA_W       = 32,
   parameter int DRAIN_CYCLES = 4
) (
   input logic                 clk,
   input logic                 rst,
   systolic_feed_ctrl_if.slave bus
);
   localparam int CW = $clog2(DRAIN_CYCLES + 8);
   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
   state_t            state;
   logic [CW-1:0]     cnt;
   logic              busy_q, done_q, arr_rst_q;
   logic [DATA_W-1:0] a_mem [16];
   logic [DATA_W-1:0] b_mem [16];
   logic [DATA_W-1:0] west_nxt [4];
   logic [DATA_W-1:0] north_nxt [4];
   logic [DATA_W-1:0] west_q [4];
   logic [DATA_W-1:0] north_q [4];
   logic [2:0]        t_nxt;
   logic              wr_ok;
   logic              feeding;
   assign wr_ok   = bus.wr_en && (state == IDLE || state == DONE);
   assign feeding = state == CLEAR || state == FEED;
   assign t_nxt   = state == FEED ? cnt[2:0] + 3'd1 : 3'd0;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.arr_rst     = arr_rst_q;
   assign bus.feed_west0  = west_q[0];
   assign bus.feed_west1  = west_q[1];
   assign bus.feed_west2  = west_q[2];
   assign bus.feed_west3  = west_q[3];
   assign bus.feed_north0 = north_q[0];
   assign bus.feed_north1 = north_q[1];
   assign bus.feed_north2 = north_q[2];
   assign bus.feed_north3 = north_q[3];
   // host writes land only while no job is reading the operands
   always_ff @(posedge clk) begin
      if (wr_ok && !bus.wr_sel) a_mem[bus.wr_addr] <= bus.wr_data;
      if (wr_ok && bus.wr_sel) b_mem[bus.wr_addr] <= bus.wr_data;
   end
   // lane i of step t carries A[i][t-i] west and B[t-i][i] north, zero outside the 4-deep diagonal
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         west_nxt[i]  = (t_nxt >= 3'(i) && t_nxt - 3'(i) <= 3'd3) ? a_mem[{2'(i), 2'(t_nxt - 3'(i))}] : '0;
         north_nxt[i] = (t_nxt >= 3'(i) && t_nxt - 3'(i) <= 3'd3) ? b_mem[{2'(t_nxt - 3'(i)), 2'(i)}] : '0;
      end
   end
   // job sequencer; the array is held cleared while the controller itself is in reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         arr_rst_q <= 1'b1;
         for (int i = 0; i < 4; i++) begin
            west_q[i]  <= '0;
            north_q[i] <= '0;
         end
      end else begin
         done_q    <= 1'b0;
         arr_rst_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            west_q[i]  <= feeding ? west_nxt[i] : '0;
            north_q[i] <= feeding ? north_nxt[i] : '0;
         end
         case (state)
            IDLE: if (bus.start) begin
               state     <= CLEAR;
               arr_rst_q <= 1'b1;
               busy_q    <= 1'b1;
            end
            CLEAR: begin
               state <= FEED;
               cnt   <= '0;
            end
            FEED: begin
               state <= cnt == CW'(6) ? DRAIN : FEED;
               cnt   <= cnt == CW'(6) ? '0 : cnt + 1'b1;
            end
            DRAIN: if (cnt == CW'(DRAIN_CYCLES - 1)) begin
               state  <= DONE;
               done_q <= 1'b1;
               busy_q <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: randomized jobs scored against a matrix-product and feed-schedule reference
module tb_systolic_feed_ctrl;
   localparam int DATA_W = 32;
   localparam int DRAIN  = 4;
   localparam int LAT    = 9 + DRAIN;
   typedef struct packed {
      logic [15:0][DATA_W-1:0] a;
      logic [15:0][DATA_W-1:0] b;
   } job_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   systolic_feed_ctrl_if #(.DATA_W(DATA_W)) bus ();
   systolic_feed_ctrl #(.DATA_W(DATA_W), .DRAIN_CYCLES(DRAIN)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   int vectors = 0;
   int miscompares = 0;
   job_t exp_q[$];
   logic [15:0][DATA_W-1:0] sh_a, sh_b;
   logic [DATA_W-1:0] fw [4];
   logic [DATA_W-1:0] fn [4];
   logic [DATA_W-1:0] feed_any;
   logic [2:0] ctl;
   assign fw[0] = bus.feed_west0;
   assign fw[1] = bus.feed_west1;
   assign fw[2] = bus.feed_west2;
   assign fw[3] = bus.feed_west3;
   assign fn[0] = bus.feed_north0;
   assign fn[1] = bus.feed_north1;
   assign fn[2] = bus.feed_north2;
   assign fn[3] = bus.feed_north3;
   assign feed_any = fw[0] | fw[1] | fw[2] | fw[3] | fn[0] | fn[1] | fn[2] | fn[3];
   assign ctl = {bus.busy, bus.done, bus.arr_rst};

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // monitor: pops a job when CLEAR appears and scores every following cycle of it
   job_t cur;
   bit active = 1'b0;
   int phase = 0;
   int t;
   logic [DATA_W-1:0] ws [4][7];
   logic [DATA_W-1:0] ns [4][7];
   logic [63:0] acc, ref_c;
   always @(negedge clk) begin
      if (!rst) begin
         active = 1'b0;
         check("reset_ctl", 64'(ctl), 64'(3'b001));
         check("reset_feeds", 64'(feed_any), 64'd0);
      end else if (!active) begin
         if (bus.arr_rst && bus.busy) begin
            check("job_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               cur = exp_q.pop_front();
               active = 1'b1;
               phase = 1;
               check("clear_feeds", 64'(feed_any), 64'd0);
            end
         end else begin
            check("idle_ctl", 64'(ctl), 64'd0);
            check("idle_feeds", 64'(feed_any), 64'd0);
         end
      end else begin
         phase++;
         if (phase <= 8) begin
            t = phase - 2;
            check($sformatf("feed_ctl_t%0d", t), 64'(ctl), 64'(3'b100));
            for (int i = 0; i < 4; i++) begin
               check($sformatf("west%0d_t%0d", i, t), 64'(fw[i]),
                     (t >= i && t - i <= 3) ? 64'(cur.a[i*4 + t - i]) : 64'd0);
               check($sformatf("north%0d_t%0d", i, t), 64'(fn[i]),
                     (t >= i && t - i <= 3) ? 64'(cur.b[(t - i)*4 + i]) : 64'd0);
               ws[i][t] = fw[i];
               ns[i][t] = fn[i];
            end
         end else if (phase < LAT) begin
            check("drain_ctl", 64'(ctl), 64'(3'b100));
            check("drain_feeds", 64'(feed_any), 64'd0);
         end else begin
            check("done_latency", 64'(ctl), 64'(3'b010));
            check("done_feeds", 64'(feed_any), 64'd0);
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) begin
                  acc = '0;
                  ref_c = '0;
                  for (int s1 = 0; s1 < 7; s1++)
                     for (int s2 = 0; s2 < 7; s2++)
                        if (s1 + c == s2 + r) acc += 64'(ws[r][s1]) * 64'(ns[c][s2]);
                  for (int k = 0; k < 4; k++) ref_c += 64'(cur.a[r*4 + k]) * 64'(cur.b[k*4 + c]);
                  check($sformatf("c%0d%0d", r, c), acc, ref_c);
               end
            active = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input bit sel, input int addr, input logic [DATA_W-1:0] d, input bit commit);
      bus.wr_en = 1'b1;
      bus.wr_sel = sel;
      bus.wr_addr = 4'(addr);
      bus.wr_data = d;
      if (commit && sel) sh_b[addr] = d;
      if (commit && !sel) sh_a[addr] = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic push_job();
      job_t j;
      j.a = sh_a;
      j.b = sh_b;
      exp_q.push_back(j);
   endtask

   task automatic start_job();
      push_job();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic start_with_write(input bit sel, input int addr, input logic [DATA_W-1:0] d);
      bus.wr_en = 1'b1;
      bus.wr_sel = sel;
      bus.wr_addr = 4'(addr);
      bus.wr_data = d;
      if (sel) sh_b[addr] = d;
      else sh_a[addr] = d;
      start_job();
      bus.wr_en = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = bus.done;
      end
      check("done_seen", 64'(seen), 64'd1);
      tick();
   endtask

   task automatic load_random();
      for (int i = 0; i < 16; i++) write(1'b0, i, DATA_W'($urandom_range(255)), 1'b1);
      for (int i = 0; i < 16; i++) write(1'b1, i, DATA_W'($urandom_range(255)), 1'b1);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1;
      rst = 1'b1;
      tick();
   endtask

   initial begin
      bus.wr_en = 1'b0;
      bus.wr_sel = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.start = 1'b0;
      repeat (3) tick();
      release_reset();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            write(1'b0, r*4 + c, DATA_W'(r == c), 1'b1);
            write(1'b1, r*4 + c, DATA_W'(4*r + c + 1), 1'b1);
         end
      start_job();
      wait_done();
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) begin
            write(1'b0, r*4 + k, DATA_W'(16*r + k), 1'b1);
            write(1'b1, r*4 + k, DATA_W'(256*r + k), 1'b1);
         end
      start_job();
      wait_done();
      load_random();
      start_job();
      wait_done();
      start_job();
      wait_done();
      start_job();
      repeat (3) tick();
      write(1'b0, 0, DATA_W'(32'hDEAD), 1'b0);
      wait_done();
      start_job();
      wait_done();
      load_random();
      start_job();
      repeat (4) tick();
      rst = 1'b0;
      repeat (2) tick();
      release_reset();
      repeat (2) tick();
      start_job();
      wait_done();
      start_with_write(1'b1, 15, DATA_W'(7));
      wait_done();
      push_job();
      push_job();
      bus.start = 1'b1;
      repeat (15) tick();
      bus.start = 1'b0;
      wait_done();
      for (int n = 0; n < 3; n++) begin
         load_random();
         repeat ($urandom_range(3)) tick();
         start_job();
         wait_done();
      end
      repeat (3) tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
